fft_frame_reader: RTL and testbench
===================================

Name: fft_frame_reader

Overview:
- Read-side controller for the ADC→FFT asynchronous FIFO; runs entirely in the FFT (read) clock domain.
- Waits until the FIFO read water level holds a full frame, then bursts exactly FRAME_LEN words out of the FIFO.
- Presents the words as a valid/ready stream with start-of-frame/end-of-frame markers to the FFT input.
- Absorbs the FIFO's 1-cycle read latency and downstream backpressure with a 2-entry skid buffer.

Parameters:
- DATA_WIDTH, 16: FIFO/stream word width.
- FRAME_LEN, 1024: words per FFT frame. Range 2..2047.
- LEVEL_W, 12: width of the FIFO water-level input.

Ports:
- rd_clk, input, 1: FFT-domain clock; all logic rising-edge.
- rd_rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: allow new frames to start.
- fifo_rd_en, output, 1: FIFO read strobe.
- fifo_rd_data, input, DATA_WIDTH: FIFO data. Valid exactly 1 cycle after fifo_rd_en.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_rd_water_level, input, LEVEL_W: words currently readable.
- m_data, output, DATA_WIDTH: stream data (skid-buffer head).
- m_valid, output, 1: stream valid.
- m_ready, input, 1: stream ready from the FFT.
- m_sop, output, 1: first word of frame; qualified by m_valid.
- m_eop, output, 1: last word of frame; qualified by m_valid.
- busy, output, 1: high in BURST or FLUSH.
- frame_cnt, output, 16: completed frames; wraps at 65535→0.
- underrun, output, 1: sticky error flag.

Behaviour:
- Reset values (async on rd_rst): FSM=IDLE, all counters 0, skid buffer empty. fifo_rd_en, m_valid, m_sop, m_eop, busy and underrun are 0. m_data=0, frame_cnt=0.
- Counters:
  - rd_cnt counts reads issued in the current frame, 0..FRAME_LEN.
  - out_cnt counts accepted beats (m_valid & m_ready), 0..FRAME_LEN-1.
  - inflight is a 1-bit register equal to fifo_rd_en of the previous cycle.
- FSM transitions:
  - IDLE: go to WAIT when enable=1.
  - WAIT: if enable=0, go to IDLE. Else if fifo_rd_water_level ≥ FRAME_LEN (unsigned compare), go to BURST next cycle and clear rd_cnt.
  - BURST: when rd_cnt reaches FRAME_LEN, go to FLUSH.
  - FLUSH: no reads. When the beat with out_cnt==FRAME_LEN-1 is accepted: clear out_cnt, increment frame_cnt, and go to WAIT if enable=1, else IDLE.
- Read issue rule: fifo_rd_en = (state==BURST) & (rd_cnt<FRAME_LEN) & ~fifo_empty & (occupancy + inflight < 2). occupancy counts skid-buffer entries, 0..2. This rule guarantees the buffer never overflows.
- Data capture: when inflight=1, fifo_rd_data is written into the skid buffer that cycle.
- Output stream:
  - m_valid = occupancy>0.
  - m_data, m_sop, m_eop come from the buffer head.
  - m_sop = (out_cnt==0); m_eop = (out_cnt==FRAME_LEN-1).
  - m_data is held stable while m_valid & ~m_ready.
  - A simultaneous push and pop keeps occupancy unchanged and preserves ordering.
- Latency: the first fifo_rd_en comes 1 cycle after WAIT sees the level. First m_valid comes 1 cycle after the first fifo_rd_en. With m_ready=1 continuously, a frame streams at 1 word/cycle with no gaps.
- enable deasserted mid-frame: the current frame always completes, then IDLE. enable only gates starting a new frame.
- Empty during BURST (rd_cnt<FRAME_LEN & fifo_empty): reads stall and underrun sets, sticky until rd_rst. The frame resumes when data returns; no words are dropped or duplicated.
- Water-level input is treated as conservative (may lag). No other flow control is assumed.
- rd_rst mid-operation: everything returns to reset values at once. In-flight FIFO data is discarded; the FIFO itself is reset by its own domain logic.

Test Plan (FRAME_LEN=16 unless noted):
1. Level 16, enable=1, m_ready=1, data 0..15 → fifo_rd_en high 16 consecutive cycles; m_valid 16 cycles starting 1 cycle later; m_sop with data 0; m_eop with data 15; frame_cnt=1; busy low after eop.
2. Level held at 15 for 100 cycles → fifo_rd_en never asserted; state stays WAIT; level raised to 16 → burst starts next cycle.
3. Random m_ready (50%) over 4 frames of sequential data → output sequence 0..63 with no loss or duplicates; sop/eop at every 16-word boundary; m_data stable while stalled; frame_cnt=4.
4. enable dropped at out_cnt=5 → remaining 11 words still delivered with eop; then IDLE and no further reads despite level ≥16.
5. fifo_empty forced high for 10 cycles at rd_cnt=7 → underrun=1 and stays 1; output words 0..15 are intact and in order after empty is released.
6. rd_rst pulsed mid-BURST at rd_cnt=9 → all outputs 0 in the same cycle (asynchronous); after release, a fresh frame starts with m_sop on the next FIFO word; frame_cnt=0.

Source files
------------

// File: rtl/fft_frame_reader.sv
// Read-domain controller that bursts one FFT frame out of the ADC->FFT async FIFO
// and presents it as a valid/ready stream with sop/eop through a 2-entry skid buffer.
module fft_frame_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 1024,
   parameter int LEVEL_W    = 12
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   input  logic [LEVEL_W-1:0]    fifo_rd_water_level,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sop,
   output logic                  m_eop,
   output logic                  busy,
   output logic [15:0]           frame_cnt,
   output logic                  underrun
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
   localparam logic [31:0]      FRAME_LEN_U = 32'(FRAME_LEN);

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            occ_q, occ_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic                  underrun_q, underrun_d;

   logic level_ok;
   logic room;
   logic reads_left;
   logic pop;
   logic last_beat;

   assign level_ok   = 32'(fifo_rd_water_level) >= FRAME_LEN_U;
   assign reads_left = rd_cnt_q < FRAME_END;
   // A read may issue only if its word is guaranteed a slot when it lands.
   assign room       = (occ_q == 2'd0) || ((occ_q == 2'd1) && !inflight_q);
   assign fifo_rd_en = (state_q == ST_BURST) && reads_left && !fifo_empty && room;
   assign inflight_d = fifo_rd_en;

   // A word arriving into an empty buffer is presented directly, so the stream
   // starts one cycle after the read and runs gap-free under continuous ready.
   assign m_valid   = (occ_q != 2'd0) || inflight_q;
   assign pop       = m_valid && m_ready;
   assign last_beat = out_cnt_q == LAST_IDX;
   assign m_sop     = m_valid && (out_cnt_q == '0);
   assign m_eop     = m_valid && last_beat;
   assign busy      = (state_q == ST_BURST) || (state_q == ST_FLUSH);
   assign frame_cnt = frame_cnt_q;
   assign underrun  = underrun_q;

   always_comb begin
      m_data = '0;
      if (occ_q != 2'd0) begin
         m_data = buf0_q;
      end else if (inflight_q) begin
         m_data = fifo_rd_data;
      end
   end

   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      occ_d  = occ_q;
      unique case (occ_q)
         2'd0: begin
            if (inflight_q && !m_ready) begin
               buf0_d = fifo_rd_data;
               occ_d  = 2'd1;
            end
         end
         2'd1: begin
            if (pop && inflight_q) begin
               buf0_d = fifo_rd_data;
            end else if (pop) begin
               occ_d = 2'd0;
            end else if (inflight_q) begin
               buf1_d = fifo_rd_data;
               occ_d  = 2'd2;
            end
         end
         default: begin
            if (pop) begin
               buf0_d = buf1_q;
               occ_d  = 2'd1;
            end
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      rd_cnt_d    = rd_cnt_q;
      frame_cnt_d = frame_cnt_q;
      out_cnt_d   = out_cnt_q;
      underrun_d  = underrun_q || ((state_q == ST_BURST) && reads_left && fifo_empty);
      if (pop) begin
         out_cnt_d = last_beat ? '0 : out_cnt_q + 1'b1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (level_ok) begin
               state_d  = ST_BURST;
               rd_cnt_d = '0;
            end
         end
         ST_BURST: begin
            if (fifo_rd_en) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               if (rd_cnt_q == LAST_IDX) state_d = ST_FLUSH;
            end
         end
         default: begin
            if (pop && last_beat) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = enable ? ST_WAIT : ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state_q     <= ST_IDLE;
         rd_cnt_q    <= '0;
         out_cnt_q   <= '0;
         inflight_q  <= 1'b0;
         occ_q       <= 2'd0;
         buf0_q      <= '0;
         buf1_q      <= '0;
         frame_cnt_q <= 16'd0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_cnt_q    <= rd_cnt_d;
         out_cnt_q   <= out_cnt_d;
         inflight_q  <= inflight_d;
         occ_q       <= occ_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         frame_cnt_q <= frame_cnt_d;
         underrun_q  <= underrun_d;
      end
   end

endmodule

// File: tb/tb_fft_frame_reader.sv
// Scoreboard bench for fft_frame_reader: a queue-based FIFO model feeds the DUT and
// every accepted stream beat is popped against the expected word/sop/eop queue.
module tb_fft_frame_reader;

   localparam int DW = 16;
   localparam int FL = 16;
   localparam int LW = 12;

   logic          rd_clk = 1'b0;
   logic          rd_rst;
   logic          enable;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_empty;
   logic [LW-1:0] fifo_rd_water_level;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_sop;
   logic          m_eop;
   logic          busy;
   logic [15:0]   frame_cnt;
   logic          underrun;

   fft_frame_reader #(
      .DATA_WIDTH (DW),
      .FRAME_LEN  (FL),
      .LEVEL_W    (LW)
   ) dut (
      .rd_clk              (rd_clk),
      .rd_rst              (rd_rst),
      .enable              (enable),
      .fifo_rd_en          (fifo_rd_en),
      .fifo_rd_data        (fifo_rd_data),
      .fifo_empty          (fifo_empty),
      .fifo_rd_water_level (fifo_rd_water_level),
      .m_data              (m_data),
      .m_valid             (m_valid),
      .m_ready             (m_ready),
      .m_sop               (m_sop),
      .m_eop               (m_eop),
      .busy                (busy),
      .frame_cnt           (frame_cnt),
      .underrun            (underrun)
   );

   always #5 rd_clk = ~rd_clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] mem_q[$];
   int            n_checks = 0;
   int            n_fails = 0;
   int            cyc = 0;
   bit            rd_pend = 0;
   bit            force_empty = 0;
   int            level_ovr = -1;
   bit            rnd_ready = 0;
   int            rd_count, first_rd, last_rd, valid_count, first_valid, acc_count;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data;
   logic [DW-1:0] next_word = '0;

   function automatic void upd_flags();
      fifo_empty = force_empty || (mem_q.size() == 0);
      fifo_rd_water_level = (level_ovr >= 0) ? LW'(level_ovr) : LW'(mem_q.size());
   endfunction

   function automatic void clear_stats();
      rd_count = 0; first_rd = -1; last_rd = -1;
      valid_count = 0; first_valid = -1; acc_count = 0;
   endfunction

   // Queue one frame into the FIFO model; optionally also into the scoreboard.
   task automatic load_frame(input bit expect_it);
      beat_t b;
      for (int i = 0; i < FL; i++) begin
         mem_q.push_back(next_word);
         b.data = next_word;
         b.sop  = (i == 0);
         b.eop  = (i == FL - 1);
         if (expect_it) exp_q.push_back(b);
         next_word = next_word + 1'b1;
      end
      upd_flags();
   endtask

   // One clock: check outputs at the falling edge, then model the FIFO after the rise.
   task automatic tick();
      beat_t b;
      @(negedge rd_clk);
      if (fifo_rd_en) begin
         rd_count++;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
      end
      if (m_valid) begin
         valid_count++;
         if (first_valid < 0) first_valid = cyc;
      end
      if (prev_stall) begin
         n_checks++;
         if (!m_valid || (m_data !== prev_data)) begin
            n_fails++;
            $display("FAIL stall_hold cyc %0d: valid=%0b data=%h, required valid=1 data=%h",
                     cyc, m_valid, m_data, prev_data);
         end
      end
      if (m_valid && m_ready) begin
         acc_count++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL beat cyc %0d: got data=%h sop=%0b eop=%0b, required no beat",
                     cyc, m_data, m_sop, m_eop);
         end else begin
            b = exp_q.pop_front();
            if ({m_data, m_sop, m_eop} !== b) begin
               n_fails++;
               $display("FAIL beat cyc %0d: got data=%h sop=%0b eop=%0b, required %h/%0b/%0b",
                        cyc, m_data, m_sop, m_eop, b.data, b.sop, b.eop);
            end
         end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      rd_pend    = fifo_rd_en;
      @(posedge rd_clk);
      cyc++;
      #1;
      if (rd_pend && (mem_q.size() != 0)) fifo_rd_data = mem_q.pop_front();
      upd_flags();
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drain(input int bound, output bit timed_out);
      int n = 0;
      while (((exp_q.size() != 0) || busy) && (n < bound)) begin
         tick();
         n++;
      end
      timed_out = (n >= bound);
   endtask

   task automatic test_reset();
      rd_rst = 1'b1; enable = 1'b0; m_ready = 1'b1; fifo_rd_data = '0;
      upd_flags();
      repeat (3) tick();
      n_checks++;
      if ({fifo_rd_en, m_valid, m_sop, m_eop, busy, underrun} !== 6'b0) begin
         n_fails++;
         $display("FAIL reset_flags: got %b, required 000000",
                  {fifo_rd_en, m_valid, m_sop, m_eop, busy, underrun});
      end
      n_checks++;
      if ((m_data !== '0) || (frame_cnt !== 16'd0)) begin
         n_fails++;
         $display("FAIL reset_values: m_data=%h frame_cnt=%0d, required 0/0", m_data, frame_cnt);
      end
      rd_rst = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ((m_valid !== 1'b0) || (busy !== 1'b0)) begin
         n_fails++;
         $display("FAIL idle_after_reset: m_valid=%0b busy=%0b, required 0/0", m_valid, busy);
      end
   endtask

   task automatic test_single_frame();
      bit to;
      clear_stats();
      load_frame(1);
      enable = 1'b1;
      drain(200, to);
      tick();
      n_checks++;
      if (to) begin n_fails++; $display("FAIL single_timeout: frame did not complete"); end
      n_checks++;
      if ((rd_count != FL) || (last_rd - first_rd != FL - 1)) begin
         n_fails++;
         $display("FAIL single_reads: count=%0d span=%0d, required %0d/%0d",
                  rd_count, last_rd - first_rd, FL, FL - 1);
      end
      n_checks++;
      if ((valid_count != FL) || (first_valid != first_rd + 1)) begin
         n_fails++;
         $display("FAIL single_valid: count=%0d first=%0d, required %0d/%0d",
                  valid_count, first_valid, FL, first_rd + 1);
      end
      n_checks++;
      if ((frame_cnt !== 16'd1) || (busy !== 1'b0)) begin
         n_fails++;
         $display("FAIL single_done: frame_cnt=%0d busy=%0b, required 1/0", frame_cnt, busy);
      end
   endtask

   task automatic test_level_threshold();
      bit to;
      int raise_cyc;
      level_ovr = FL - 1;
      clear_stats();
      load_frame(1);
      repeat (100) tick();
      n_checks++;
      if ((rd_count != 0) || (busy !== 1'b0)) begin
         n_fails++;
         $display("FAIL level_hold: reads=%0d busy=%0b, required 0/0", rd_count, busy);
      end
      level_ovr = -1;
      upd_flags();
      raise_cyc = cyc;
      drain(200, to);
      n_checks++;
      if (to) begin n_fails++; $display("FAIL level_timeout: frame did not complete"); end
      n_checks++;
      if (first_rd != raise_cyc + 1) begin
         n_fails++;
         $display("FAIL level_start: first read cyc %0d, required %0d", first_rd, raise_cyc + 1);
      end
      n_checks++;
      if (frame_cnt !== 16'd2) begin
         n_fails++;
         $display("FAIL level_frames: frame_cnt=%0d, required 2", frame_cnt);
      end
   endtask

   task automatic test_random_ready();
      bit to;
      rnd_ready = 1'b1;
      for (int f = 0; f < 4; f++) load_frame(1);
      drain(3000, to);
      rnd_ready = 1'b0;
      m_ready = 1'b1;
      n_checks++;
      if (to) begin n_fails++; $display("FAIL random_timeout: frames did not complete"); end
      n_checks++;
      if (frame_cnt !== 16'd6) begin
         n_fails++;
         $display("FAIL random_frames: frame_cnt=%0d, required 6", frame_cnt);
      end
   endtask

   task automatic test_enable_drop();
      bit to;
      int n = 0;
      clear_stats();
      load_frame(1);
      load_frame(0);
      while ((acc_count < 5) && (n < 100)) begin
         tick();
         n++;
      end
      enable = 1'b0;
      drain(200, to);
      repeat (30) tick();
      n_checks++;
      if (to || (n >= 100)) begin n_fails++; $display("FAIL drop_timeout: frame did not complete"); end
      n_checks++;
      if ((rd_count != FL) || (busy !== 1'b0)) begin
         n_fails++;
         $display("FAIL drop_idle: reads=%0d busy=%0b, required %0d/0", rd_count, busy, FL);
      end
      n_checks++;
      if (frame_cnt !== 16'd7) begin
         n_fails++;
         $display("FAIL drop_frames: frame_cnt=%0d, required 7", frame_cnt);
      end
      mem_q.delete();
      upd_flags();
   endtask

   task automatic test_underrun();
      bit to;
      int n = 0;
      enable = 1'b1;
      clear_stats();
      n_checks++;
      if (underrun !== 1'b0) begin
         n_fails++;
         $display("FAIL underrun_pre: underrun=%0b, required 0", underrun);
      end
      load_frame(1);
      while ((rd_count < 7) && (n < 100)) begin
         tick();
         n++;
      end
      force_empty = 1'b1;
      upd_flags();
      repeat (10) tick();
      n_checks++;
      if ((rd_count != 7) || (underrun !== 1'b1)) begin
         n_fails++;
         $display("FAIL underrun_stall: reads=%0d underrun=%0b, required 7/1", rd_count, underrun);
      end
      force_empty = 1'b0;
      upd_flags();
      drain(200, to);
      n_checks++;
      if (to || (n >= 100)) begin n_fails++; $display("FAIL underrun_timeout: frame incomplete"); end
      n_checks++;
      if ((underrun !== 1'b1) || (frame_cnt !== 16'd8)) begin
         n_fails++;
         $display("FAIL underrun_post: underrun=%0b frame_cnt=%0d, required 1/8",
                  underrun, frame_cnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit to;
      int n = 0;
      clear_stats();
      load_frame(1);
      while ((rd_count < 9) && (n < 100)) begin
         tick();
         n++;
      end
      #2;
      rd_rst = 1'b1;
      #1;
      n_checks++;
      if ({fifo_rd_en, m_valid, m_sop, m_eop, busy, underrun} !== 6'b0) begin
         n_fails++;
         $display("FAIL async_rst_flags: got %b, required 000000",
                  {fifo_rd_en, m_valid, m_sop, m_eop, busy, underrun});
      end
      n_checks++;
      if ((m_data !== '0) || (frame_cnt !== 16'd0)) begin
         n_fails++;
         $display("FAIL async_rst_values: m_data=%h frame_cnt=%0d, required 0/0", m_data, frame_cnt);
      end
      mem_q.delete();
      exp_q.delete();
      prev_stall = 0;
      upd_flags();
      tick();
      rd_rst = 1'b0;
      clear_stats();
      load_frame(1);
      drain(200, to);
      n_checks++;
      if (to || (n >= 100)) begin n_fails++; $display("FAIL rst_timeout: frame incomplete"); end
      n_checks++;
      if ((frame_cnt !== 16'd1) || (underrun !== 1'b0) || (rd_count != FL)) begin
         n_fails++;
         $display("FAIL rst_fresh: frame_cnt=%0d underrun=%0b reads=%0d, required 1/0/%0d",
                  frame_cnt, underrun, rd_count, FL);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_level_threshold();
      test_random_ready();
      test_enable_drop();
      test_underrun();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
